// File: rtl/switch_pkg.sv
// Shared switch definitions: stream tags, merge FSM encoding and default data width.
// Also used by the class/demux side of the device.
package switch_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TAG_W  = 2;

  // Source tag carried in the top bits of every merged word.
  localparam logic [TAG_W-1:0] TAG_IDLE = 2'b00;
  localparam logic [TAG_W-1:0] TAG_F0   = 2'b01;
  localparam logic [TAG_W-1:0] TAG_F1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } merge_state_t;

endpackage

// File: rtl/rr_merge2.sv
// Round-robin merge of two FIFO read streams into one tagged stream.
// Ports:
//   clk, reset            clock, async active-low reset
//   fifoN_data            FIFO N read data, valid the cycle after popN
//   fifoN_empty/_error    FIFO N status flags
//   pause                 downstream backpressure, blocks new pops
//   pop0, pop1            combinational read strobes to the FIFOs
//   out, valid_out        registered {tag, data} word and its qualifier
//   Error                 sticky FIFO error flag
module rr_merge2 #(
  parameter int unsigned BURST  = 2,
  parameter int unsigned DATA_W = switch_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo0_data,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              fifo0_empty,
  input  logic              fifo1_empty,
  input  logic              fifo0_error,
  input  logic              fifo1_error,
  input  logic              pause,
  output logic              pop0,
  output logic              pop1,
  output logic [DATA_W+1:0] out,
  output logic              valid_out,
  output logic              Error
);

  import switch_pkg::*;

  localparam int unsigned CNT_W      = 3;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

  merge_state_t     state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             rd_pending_q;
  logic             rd_src_q;

  // Granted / other FIFO as seen from the current grant state.
  logic gnt1, own_empty, oth_empty;
  assign gnt1      = (state_q == ST_GRANT1);
  assign own_empty = gnt1 ? fifo1_empty : fifo0_empty;
  assign oth_empty = gnt1 ? fifo0_empty : fifo1_empty;

  // Next-state, pop strobes and burst counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bcnt_d = '0;
        // On a tie, serve the FIFO that was not served last.
        if (!fifo0_empty && (fifo1_empty || last_q)) begin
          state_d = ST_GRANT0;
        end else if (!fifo1_empty) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!pause) begin
          if (!own_empty) begin
            pop0   = !gnt1;
            pop1   = gnt1;
            last_d = gnt1;
            if (bcnt_q == BURST_LAST && !oth_empty) begin
              state_d = gnt1 ? ST_GRANT0 : ST_GRANT1;
              bcnt_d  = '0;
            end else if (bcnt_q != BURST_LAST) begin
              // Saturate so a later non-empty other FIFO switches on the next pop.
              bcnt_d = bcnt_q + CNT_W'(1);
            end
          end else begin
            bcnt_d  = '0;
            state_d = oth_empty ? ST_IDLE : (gnt1 ? ST_GRANT0 : ST_GRANT1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // Arbiter state; last starts at 1 so FIFO0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Read pipeline: capture FIFO data the cycle after the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending_q <= 1'b0;
      rd_src_q     <= 1'b0;
      out          <= '0;
      valid_out    <= 1'b0;
    end else begin
      rd_pending_q <= pop0 | pop1;
      rd_src_q     <= pop1;
      if (rd_pending_q) begin
        out       <= rd_src_q ? {TAG_F1, fifo1_data} : {TAG_F0, fifo0_data};
        valid_out <= 1'b1;
      end else begin
        out       <= {TAG_IDLE, DATA_W'(0)};
        valid_out <= 1'b0;
      end
    end
  end

  // Sticky error, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Error <= 1'b0;
    end else if (fifo0_error || fifo1_error) begin
      Error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_merge2.sv
// Scoreboard bench for rr_merge2: queue-based FIFO models feed the DUT, a
// monitor compares emitted words against expected queues and timing rules.
module tb_rr_merge2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fifo0_data = 8'h00;
  logic [7:0] fifo1_data = 8'h00;
  logic       fifo0_empty = 1'b1;
  logic       fifo1_empty = 1'b1;
  logic       fifo0_error = 1'b0;
  logic       fifo1_error = 1'b0;
  logic       pause = 1'b0;
  logic       pop0, pop1;
  logic [9:0] out;
  logic       valid_out;
  logic       Error;

  rr_merge2 #(.BURST(2), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .fifo0_data(fifo0_data), .fifo1_data(fifo1_data),
    .fifo0_empty(fifo0_empty), .fifo1_empty(fifo1_empty),
    .fifo0_error(fifo0_error), .fifo1_error(fifo1_error),
    .pause(pause), .pop0(pop0), .pop1(pop1),
    .out(out), .valid_out(valid_out), .Error(Error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [9:0] exp_all[$];
  logic [7:0] exp_s0[$];
  logic [7:0] exp_s1[$];
  bit         ordered = 1'b1;
  int         cur_run = 0;
  int         max_run = 0;
  bit         saw_pop1 = 1'b0;
  logic       h1_v = 1'b0, h1_s = 1'b0, h2_v = 1'b0, h2_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO models: data appears the cycle after a pop, empty flag is registered.
  always @(posedge clk) begin
    if (pop0) begin
      check("pop0_not_empty", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) fifo0_data <= q0.pop_front();
    end
    if (pop1) begin
      check("pop1_not_empty", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) fifo1_data <= q1.pop_front();
    end
    fifo0_empty <= (q0.size() == 0);
    fifo1_empty <= (q1.size() == 0);
  end

  // Monitor: reset behaviour, pop rules, two-cycle latency, scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_valid", 32'(valid_out), 0);
      check("rst_out", 32'(out), 0);
      check("rst_pops", 32'({pop0, pop1}), 0);
      h1_v = 1'b0;
      h2_v = 1'b0;
      cur_run = 0;
    end else begin
      check("latency_valid", 32'(valid_out), 32'(h2_v));
      if (pop0 || pop1) check("single_pop", 32'(pop0 & pop1), 0);
      if (pause) check("pause_no_pop", 32'(pop0 | pop1), 0);
      if (pop1) saw_pop1 = 1'b1;
      if (valid_out) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (h2_v) check("latency_tag", 32'(out[9:8]), h2_s ? 32'h2 : 32'h1);
        if (ordered) begin
          check("word_expected", 32'(exp_all.size() != 0), 1);
          if (exp_all.size() != 0) check("ordered_word", 32'(out), 32'(exp_all.pop_front()));
        end else if (out[9:8] == 2'b01) begin
          check("s0_expected", 32'(exp_s0.size() != 0), 1);
          if (exp_s0.size() != 0) check("s0_word", 32'(out[7:0]), 32'(exp_s0.pop_front()));
        end else if (out[9:8] == 2'b10) begin
          check("s1_expected", 32'(exp_s1.size() != 0), 1);
          if (exp_s1.size() != 0) check("s1_word", 32'(out[7:0]), 32'(exp_s1.pop_front()));
        end else begin
          check("valid_tag", 32'(out[9:8]), 1);
        end
      end else begin
        cur_run = 0;
        check("idle_out", 32'(out), 0);
      end
      h2_v = h1_v;
      h2_s = h1_s;
      h1_v = pop0 | pop1;
      h1_s = pop1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int src, input logic [7:0] d);
    if (src == 0) begin
      q0.push_back(d);
      if (!ordered) exp_s0.push_back(d);
    end else begin
      q1.push_back(d);
      if (!ordered) exp_s1.push_back(d);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_all.size() != 0 ||
            exp_s0.size() != 0 || exp_s1.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    check({name, "_drained"}, 32'(k < 300), 1);
    repeat (4) tick();
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid_out && k < 30);
    check({name, "_first_word"}, 32'(valid_out), 1);
  endtask

  initial begin
    // Reset held with both FIFOs loaded; round-robin order expected on release.
    ordered = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, 8'h10 + 8'(i));
      push(1, 8'h20 + 8'(i));
    end
    exp_all = '{10'h110, 10'h111, 10'h220, 10'h221, 10'h112, 10'h113, 10'h222, 10'h223};
    repeat (4) begin
      @(negedge clk);
      check("rst_error", 32'(Error), 0);
    end
    max_run = 0;
    tick();
    reset = 1'b1;
    drain("rr");
    check("rr_no_bubble", 32'(max_run), 8);

    // Single source: FIFO1 never popped.
    saw_pop1 = 1'b0;
    max_run = 0;
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    exp_all = '{10'h1A1, 10'h1A2, 10'h1A3};
    drain("single");
    check("single_run", 32'(max_run), 3);
    check("single_no_pop1", 32'(saw_pop1), 0);

    // Pause mid-burst: in-flight words still emerge, nothing lost.
    for (int i = 0; i < 6; i++) begin
      push(0, 8'h30 + 8'(i));
      exp_all.push_back(10'h130 + 10'(i));
    end
    wait_valid("pause");
    @(posedge clk); #1;
    pause = 1'b1;
    @(negedge clk); check("pause_inflight1", 32'(valid_out), 1);
    tick();
    @(negedge clk); check("pause_inflight2", 32'(valid_out), 1);
    tick();
    @(negedge clk); check("pause_bubble", 32'(valid_out), 0);
    tick();
    pause = 1'b0;
    drain("pause");

    // Sticky error.
    fifo1_error = 1'b1;
    @(negedge clk); check("err_before", 32'(Error), 0);
    tick();
    fifo1_error = 1'b0;
    repeat (4) begin
      @(negedge clk); check("err_sticky", 32'(Error), 1);
      tick();
    end

    // Reset while a word is pending: that word is lost, FIFO0 wins the tie after.
    push(0, 8'h60); push(0, 8'h61); push(0, 8'h62);
    exp_all = '{10'h160, 10'h162, 10'h270, 10'h271};
    wait_valid("rstmid");
    #1;
    reset = 1'b0;
    push(1, 8'h70); push(1, 8'h71);
    #1;
    check("rstmid_valid_drop", 32'(valid_out), 0);
    check("rstmid_error_clr", 32'(Error), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drain("rstmid");

    // Random traffic with random backpressure, per-source ordering.
    ordered = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      pause = ($urandom_range(0, 4) == 0);
      if (q0.size() < 6 && $urandom_range(0, 2) == 0) push(0, 8'($urandom));
      if (q1.size() < 6 && $urandom_range(0, 3) == 0) push(1, 8'($urandom));
    end
    pause = 1'b0;
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_merge2.md
# rr_merge2

Downstream stage of the class-based demux device (`device1`): merges its two 8-bit FIFO output streams (fifo6x8 #0 and #1) back into a single 10-bit tagged stream. A round-robin arbiter with burst limiting pops the FIFOs, honours downstream pause, and raises a sticky error flag when either FIFO reports an error. Output feeds the next switching stage / egress port.

## Interface
- `BURST`, 2: max consecutive pops from one FIFO while the other is non-empty (1..7)
- `DATA_W`, 8: FIFO data width; output width is DATA_W+2

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `fifo0_data`  in  8  fifo6x8 #0 read data, valid the cycle after `pop0`
- `fifo1_data`  in  8  fifo6x8 #1 read data, valid the cycle after `pop1`
- `fifo0_empty`, `fifo1_empty`  in  1  FIFO empty flags
- `fifo0_error`, `fifo1_error`  in  1  FIFO over/underflow flags
- `pause`  in  1  downstream backpressure; no pops while high
- `pop0`, `pop1`  out  1  read strobes to the FIFOs (combinational from state + inputs)
- `out`  out  10  `{tag[1:0], data[7:0]}`; tag 01 = FIFO0, 10 = FIFO1, 00 = idle
- `valid_out`  out  1  `out` carries a word this cycle
- `Error`  out  1  sticky error flag

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Registers: `state`, `last` (last FIFO served, 1 bit), `bcnt` (3 bits), `rd_pending`, `rd_src`, `out`, `valid_out`, `Error`.
- IDLE: if exactly one FIFO is non-empty, grant it; if both, grant the FIFO that is not `last`; else stay.
- GRANTx: `popx = !fifox_empty && !pause`. Each pop increments `bcnt` and sets `last = x`.
  - pop with `bcnt == BURST-1` and other FIFO non-empty → GRANT(other), `bcnt = 0` (no bubble).
  - `fifox_empty` (no pop) and other non-empty → GRANT(other), `bcnt = 0`.
  - `fifox_empty` and other empty → IDLE, `bcnt = 0`.
  - `pause` high → state and `bcnt` hold.
- Never pops both FIFOs in one cycle; never pops an empty FIFO.
- Read pipeline: pop in cycle t sets `rd_pending = 1`, `rd_src = x`. At the edge ending t+1, `out <= {tag(rd_src), fifox_data}` and `valid_out <= 1`. Otherwise `out <= 0` and `valid_out <= 0`.
- `pause` does not cancel a pop already issued; that word still emerges one cycle later.
- `Error` is set on any cycle with `fifo0_error | fifo1_error` and is cleared only by reset.

## Timing
- Reset (`reset` = 0, async): `state` = IDLE, `last` = 1 (so FIFO0 wins the first tie), `bcnt` = 0, `rd_pending` = 0, `out` = 10'h000, `valid_out` = 0, `Error` = 0, `pop0` = `pop1` = 0. Data in flight is discarded.
- Latency: pop in cycle t → `valid_out` in cycle t+2.
- First grant from IDLE costs 1 cycle: FIFO goes non-empty in cycle t → pop in t+1 → out in t+3.
- Sustained throughput: 1 word/cycle while the granted FIFO is non-empty and `pause` is low.
- Emptying the granted FIFO costs one bubble cycle before the switch.
- Reset deasserted mid-stream: first pop no earlier than one cycle after the FSM leaves IDLE.

## Structure
- Shared package `switch_pkg`: tag constants `TAG_IDLE` = 2'b00, `TAG_F0` = 2'b01, `TAG_F1` = 2'b10; FSM state encoding; `DATA_W`. The same package is reused by the class/demux side.
- Single module; no sub-module needed. Grant logic and output register live in one file, plus a hand-synthesised `rr_merge2_syn` for the usual behavioural-vs-synth comparison bench.

## Test plan
- Reset: hold `reset` = 0 with both FIFOs non-empty → `out` = 0, `valid_out` = 0, `pop0` = `pop1` = 0, `Error` = 0.
- Single source: FIFO0 holds 8'hA1, 8'hA2, 8'hA3; FIFO1 empty → `out` = 10'h1A1, 10'h1A2, 10'h1A3 on consecutive cycles; `pop1` never asserted.
- Round-robin with BURST = 2: FIFO0 holds 8'h10..8'h13, FIFO1 holds 8'h20..8'h23, both loaded before reset release → tags 01,01,10,10,01,01,10,10 with data 10,11,20,21,12,13,22,23, no bubbles.
- Pause: assert `pause` for 3 cycles mid-burst → pops stop the same cycle; the already-issued word still appears one cycle later; the sequence resumes without loss or duplication.
- Error sticky: pulse `fifo1_error` for 1 cycle → `Error` = 1 next cycle and stays 1 until `reset` = 0.
- Reset mid-operation: assert `reset` while `rd_pending` = 1 → `valid_out` drops immediately; after release the first output is the next unpopped FIFO word, with FIFO0 winning the tie.
